// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// flag bit positions, operand classes and width-generic encoding helpers.
package fp_mul_pkg;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UDF = 1;
   localparam int FLG_INX = 0;

   // Widest word the helpers below can build; callers slice to their own width.
   localparam int FP_MAX_W = 128;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_INF  = 2'd1,
      CLS_NAN  = 2'd2,
      CLS_NORM = 2'd3
   } fp_cls_e;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical NaN: sign 0, exponent and mantissa all ones.
   function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
      logic [FP_MAX_W-1:0] one;
      one = FP_MAX_W'(1);
      return (one << (exp_w + man_w)) - one;
   endfunction

endpackage

// File: rtl/fpm_round_pack.sv
// Stage-3 normalise, round and special-case select for fp_multiplier_pipe.
// FPMUL_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fpm_round_pack
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     sign,
   input  fp_cls_e                  cls_a,
   input  fp_cls_e                  cls_b,
   input  logic [2*MAN_W+1:0]       prod,
   input  logic signed [EXP_W+1:0]  exp_in,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;

   localparam logic [FP_MAX_W-1:0]   NAN_FULL = fp_canon_nan(EXP_W, MAN_W);
   localparam logic [W-1:0]          NAN_WORD = NAN_FULL[W-1:0];
   localparam logic signed [EW2-1:0] E_MAX    = $signed({2'b00, {EXP_W{1'b1}}});
   localparam logic signed [EW2-1:0] E_ONE    = EW2'(1);
   localparam logic signed [EW2-1:0] E_ZERO   = EW2'(0);

   logic [MAN_W-1:0]        mant_raw;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [MAN_W:0]          mant_sum;
   logic signed [EW2-1:0]   e_norm;
   logic signed [EW2-1:0]   e_final;
   logic                    any_nan;
   logic                    any_inf;
   logic                    any_zero;

   // Product of two [1,2) significands lies in [1,4); bring it back to [1,2).
   always_comb begin
      if (prod[2*MAN_W+1]) begin
         mant_raw = prod[2*MAN_W -: MAN_W];
         guard    = prod[MAN_W];
         sticky   = |prod[MAN_W-1:0];
         e_norm   = exp_in + E_ONE;
      end else begin
         mant_raw = prod[2*MAN_W-1 -: MAN_W];
         guard    = prod[MAN_W-1];
         sticky   = |prod[MAN_W-2:0];
         e_norm   = exp_in;
      end
   end

   always_comb begin
`ifdef FPMUL_RNE_EN
      round_up = guard & (sticky | mant_raw[0]);
`else
      round_up = 1'b0;
`endif
      mant_sum = {1'b0, mant_raw} + {{MAN_W{1'b0}}, round_up};
      // A carry out leaves the stored mantissa at zero and bumps the exponent.
      e_final  = mant_sum[MAN_W] ? (e_norm + E_ONE) : e_norm;
   end

   always_comb begin
      any_nan  = (cls_a == CLS_NAN)  || (cls_b == CLS_NAN);
      any_inf  = (cls_a == CLS_INF)  || (cls_b == CLS_INF);
      any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);

      result          = {sign, e_final[EXP_W-1:0], mant_sum[MAN_W-1:0]};
      flags           = 4'b0000;
      flags[FLG_INX]  = guard | sticky;

      if (any_nan || (any_inf && any_zero)) begin
         result         = NAN_WORD;
         flags          = 4'b0000;
         flags[FLG_INV] = 1'b1;
      end else if (any_inf) begin
         result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags  = 4'b0000;
      end else if (any_zero) begin
         result = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         flags  = 4'b0000;
      end else if (e_final >= E_MAX) begin
         result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags          = 4'b0000;
         flags[FLG_OVF] = 1'b1;
         flags[FLG_INX] = 1'b1;
      end else if (e_final <= E_ZERO) begin
         result         = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
         flags          = 4'b0000;
         flags[FLG_UDF] = 1'b1;
         flags[FLG_INX] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Define FPMUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_multiplier_pipe
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic [3:0]             out_flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int EW2  = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int BIAS = fp_bias(EXP_W);
   localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);

   logic                    en;

   logic                    s1_valid;
   logic                    s1_sa;
   logic                    s1_sb;
   fp_cls_e                 s1_cls_a;
   fp_cls_e                 s1_cls_b;
   logic [EXP_W-1:0]        s1_ea;
   logic [EXP_W-1:0]        s1_eb;
   logic [MAN_W:0]          s1_ma;
   logic [MAN_W:0]          s1_mb;

   logic                    s2_valid;
   logic                    s2_sign;
   fp_cls_e                 s2_cls_a;
   fp_cls_e                 s2_cls_b;
   logic [PW-1:0]           s2_prod;
   logic signed [EW2-1:0]   s2_exp;

   logic [W-1:0]            rp_result;
   logic [3:0]              rp_flags;

   // Denormal encodings (exponent 0) are flushed to signed zero.
   function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      if (e == {EXP_W{1'b0}}) begin
         return CLS_ZERO;
      end else if (e == {EXP_W{1'b1}}) begin
         return (m == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
      end else begin
         return CLS_NORM;
      end
   endfunction

   // The whole pipe advances in lockstep whenever the output slot can move.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s1_sa    <= in_a[W-1];
         s1_sb    <= in_b[W-1];
         s1_cls_a <= classify(in_a[W-2 -: EXP_W], in_a[MAN_W-1:0]);
         s1_cls_b <= classify(in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]);
         s1_ea    <= in_a[W-2 -: EXP_W];
         s1_eb    <= in_b[W-2 -: EXP_W];
         s1_ma    <= {1'b1, in_a[MAN_W-1:0]};
         s1_mb    <= {1'b1, in_b[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s2_sign  <= s1_sa ^ s1_sb;
         s2_cls_a <= s1_cls_a;
         s2_cls_b <= s1_cls_b;
         s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
         s2_exp   <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS_S;
      end
   end

   fpm_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round_pack (
      .sign   (s2_sign),
      .cls_a  (s2_cls_a),
      .cls_b  (s2_cls_b),
      .prod   (s2_prod),
      .exp_in (s2_exp),
      .result (rp_result),
      .flags  (rp_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (en) begin
         out_valid  <= s2_valid;
         out_result <= rp_result;
         out_flags  <= rp_flags;
      end
   end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed self-checking bench for fp_multiplier_pipe (EXP_W=8, MAN_W=23).
module tb_fp_multiplier_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   fp_multiplier_pipe #(
      .EXP_W (8),
      .MAN_W (23)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   logic [31:0] s_a   [10] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'hC0000000, 32'h40A00000,
                               32'h00000000, 32'h41200000, 32'h40400000, 32'h40E00000, 32'h40C00000};
   logic [31:0] s_b   [10] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40A00000,
                               32'h40E00000, 32'h41200000, 32'h40400000, 32'hBF800000, 32'h3F000000};
   logic [31:0] s_exp [10] = '{32'h40000000, 32'h40C00000, 32'h40400000, 32'hC1000000, 32'h41C80000,
                               32'h00000000, 32'h42C80000, 32'h41100000, 32'hC0E00000, 32'h40400000};

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vec++;
      assert (observed === expected) else begin
         n_miss++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Latency counts negedges after the accept edge until out_valid shows.
   task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input logic [3:0] exp_flags);
      int lat;
      applyStimulus(a, b);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'd3);
      checkOutput({tag, " result"}, out_result, exp_res);
      checkOutput({tag, " flags"}, {28'd0, out_flags}, {28'd0, exp_flags});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   sent;
      int   recv;
      int   cyc;
      logic stalled;
      logic fire_in;
      logic seen;
      logic [31:0] held_res;
      logic [3:0]  held_flags;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_result", out_result, 32'h0);
      checkOutput("reset out_flags", {28'd0, out_flags}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
      checkOutput("out_valid after reset", 32'(out_valid), 32'd0);

      runDirected("1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
`ifdef FPMUL_RNE_EN
      runDirected("round tie-odd", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
`else
      runDirected("round tie-odd", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'h1);
`endif
      runDirected("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5);
      runDirected("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'h3);
      runDirected("inf x zero", 32'h7F800000, 32'h00000000, 32'h7FFFFFFF, 4'h8);
      runDirected("neg x inf", 32'hC0000000, 32'h7F800000, 32'hFF800000, 4'h0);

      // Streaming under random backpressure.
      sent       = 0;
      recv       = 0;
      cyc        = 0;
      stalled    = 1'b0;
      held_res   = '0;
      held_flags = '0;
      while (recv < 10 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            checkOutput("stall out_valid held", 32'(out_valid), 32'd1);
            checkOutput("stall result held", out_result, held_res);
            checkOutput("stall flags held", {28'd0, out_flags}, {28'd0, held_flags});
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 10);
         if (sent < 10) begin
            in_a = s_a[sent];
            in_b = s_b[sent];
         end
         #1;
         stalled = out_valid && !out_ready;
         if (stalled) begin
            held_res   = out_result;
            held_flags = out_flags;
         end
         if (out_valid && out_ready) begin
            checkOutput($sformatf("stream %0d result", recv), out_result, s_exp[recv]);
            checkOutput($sformatf("stream %0d flags", recv), {28'd0, out_flags}, 32'h0);
            recv++;
         end
         fire_in = in_valid && in_ready;
         @(posedge clk);
         if (fire_in) sent++;
      end
      #1 in_valid = 1'b0;
      checkOutput("stream received count", 32'(recv), 32'd10);
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkOutput("stream no extra results", 32'(seen), 32'd0);

      // Fill the pipe with the output stalled, then reset mid-stream.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 32'h40400000;
      in_b      = 32'h40400000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("async reset out_result", out_result, 32'h0);
      checkOutput("async reset out_flags", {28'd0, out_flags}, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      seen      = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkOutput("no stale result after reset", 32'(seen), 32'd0);
      runDirected("post-reset 1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
